// File: rtl/comb_sched.sv
// Sequencer for the per-sample comb update stage: pairs dot-product words with
// labels, feeds the comb stage and pipelines its result to the weight-update unit.
module comb_sched #(
    parameter int BITWIDTH       = 32,
    parameter int INPUT_BITWIDTH = 16,
    parameter int COMB_LAT       = 2,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_samples,
    input  logic [INPUT_BITWIDTH-1:0] mu_cfg,
    output logic                      busy,
    output logic                      done,
    input  logic                      dot_valid,
    output logic                      dot_ready,
    input  logic [BITWIDTH-1:0]       dot_data,
    input  logic                      label_valid,
    output logic                      label_ready,
    input  logic [INPUT_BITWIDTH-1:0] label_data,
    output logic [BITWIDTH-1:0]       comb_data_in,
    output logic [INPUT_BITWIDTH-1:0] comb_bias,
    output logic [INPUT_BITWIDTH-1:0] comb_mu,
    output logic                      comb_valid,
    input  logic [BITWIDTH-1:0]       comb_data_out,
    output logic                      grad_valid,
    input  logic                      grad_ready,
    output logic [BITWIDTH-1:0]       grad_data,
    output logic                      grad_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]                 n_tgt, issue_cnt, retire_cnt;
    logic signed [INPUT_BITWIDTH-1:0] mu_r;
    logic signed [BITWIDTH-1:0]       data_p0;
    logic signed [INPUT_BITWIDTH-1:0] bias_p0;
    logic                             vld_p0;
    logic signed [BITWIDTH-1:0]       data_pn [1:COMB_LAT-1];
    logic                             vld_pn  [1:COMB_LAT-1];
    logic                             start_ok, stall, issue, grad_hs;

    // A stalled output freezes the whole pipe, so issue is blocked by the same term.
    assign start_ok = (state == IDLE) && start;
    assign stall    = grad_valid && !grad_ready;
    assign issue    = (state == RUN) && dot_valid && label_valid && (issue_cnt < n_tgt) && !stall;
    assign grad_hs  = grad_valid && grad_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = start_ok || (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
            RUN:     if (issue_cnt == n_tgt) state_nxt = DRAIN;
            DRAIN:   if (grad_hs && grad_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_tgt      <= '0;
            mu_r       <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
        end else if (start_ok) begin
            n_tgt      <= num_samples;
            mu_r       <= mu_cfg;
            issue_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (issue)   issue_cnt  <= issue_cnt + 1'b1;
            if (grad_hs) retire_cnt <= retire_cnt + 1'b1;
        end
    end

    // Stage 0: operand register feeding the comb stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            bias_p0 <= '0;
        end else if (!stall) begin
            vld_p0 <= issue;
            if (issue) begin
                data_p0 <= dot_data;
                bias_p0 <= label_data;
            end
        end
    end

    // Stage 1 captures the comb result; later stages are plain delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < COMB_LAT; k++) begin
                data_pn[k] <= '0;
                vld_pn[k]  <= 1'b0;
            end
        end else if (!stall) begin
            vld_pn[1] <= vld_p0;
            if (vld_p0) data_pn[1] <= comb_data_out;
            for (int k = 2; k < COMB_LAT; k++) begin
                data_pn[k] <= data_pn[k-1];
                vld_pn[k]  <= vld_pn[k-1];
            end
        end
    end

    assign dot_ready    = issue;
    assign label_ready  = issue;
    assign comb_data_in = data_p0;
    assign comb_bias    = bias_p0;
    assign comb_mu      = mu_r;
    assign comb_valid   = vld_p0;
    assign grad_data    = data_pn[COMB_LAT-1];
    assign grad_valid   = vld_pn[COMB_LAT-1];
    assign grad_last    = grad_valid && (retire_cnt == n_tgt - CNT_W'(1));
endmodule

// File: tb/tb_comb_sched.sv
// Directed bench for comb_sched: scoreboard of expected gradients pushed at issue
// and popped at each grad handshake, plus batch-level timing and count checks.
module tb_comb_sched;
    localparam int BW  = 32;
    localparam int IW  = 16;
    localparam int LAT = 2;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done;
    logic [CW-1:0] num_samples;
    logic [IW-1:0] mu_cfg;
    logic          dot_valid, dot_ready, label_valid, label_ready;
    logic [BW-1:0] dot_data;
    logic [IW-1:0] label_data;
    logic [BW-1:0] comb_data_in, comb_data_out, grad_data;
    logic [IW-1:0] comb_bias, comb_mu;
    logic          comb_valid, grad_valid, grad_ready, grad_last;

    typedef struct {
        logic [BW-1:0] val;
        int            c;
    } exp_t;
    exp_t q[$];

    int            total, bad, cyc, si;
    int            n_iss, n_ret, n_done, n_busy, first_iss, last_iss, last_beat, done_cyc;
    int            exp_n;
    logic [IW-1:0] mu_m;
    logic          chk_lat, hold_chk, tog;
    logic [BW-1:0] held;

    always #5 clk = ~clk;

    comb_sched #(.BITWIDTH(BW), .INPUT_BITWIDTH(IW), .COMB_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .mu_cfg(mu_cfg),
        .busy(busy), .done(done), .dot_valid(dot_valid), .dot_ready(dot_ready),
        .dot_data(dot_data), .label_valid(label_valid), .label_ready(label_ready),
        .label_data(label_data), .comb_data_in(comb_data_in), .comb_bias(comb_bias),
        .comb_mu(comb_mu), .comb_valid(comb_valid), .comb_data_out(comb_data_out),
        .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
        .grad_last(grad_last)
    );

    function automatic logic [BW-1:0] grad_of(logic [BW-1:0] d, logic [IW-1:0] b, logic [IW-1:0] m);
        longint dd, bb, mm;
        dd = longint'($signed(d));
        bb = longint'($signed(b));
        mm = longint'($signed(m));
        return BW'((dd - bb) * mm);
    endfunction

    function automatic logic [BW-1:0] dot_of(int i);
        return BW'(i * 911 - 3000);
    endfunction

    function automatic logic [IW-1:0] lab_of(int i);
        return IW'(i * 37 - 200);
    endfunction

    // external comb stage: (x - label) * mu
    assign comb_data_out = comb_valid ? grad_of(comb_data_in, comb_bias, comb_mu) : '0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(string tag);
        chk(tag, {busy, done, dot_ready, label_ready, comb_valid, grad_valid, grad_last,
                  comb_data_in, comb_bias, comb_mu, grad_data}, '0);
    endtask

    task automatic monitor();
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            hold_chk = 1'b0;
            return;
        end
        if (dot_ready || label_ready) begin
            chk("lockstep", label_ready, dot_ready);
            chk("rdy_gated", dot_valid & label_valid, 1'b1);
        end
        if (grad_valid && !grad_ready) chk("stall_no_issue", dot_ready, 1'b0);
        if (dot_ready) begin
            e.val = grad_of(dot_data, label_data, mu_m);
            e.c   = cyc;
            q.push_back(e);
            if (n_iss == 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
        end
        if (comb_valid) chk("comb_mu", comb_mu, mu_m);
        if (hold_chk) begin
            chk("hold_valid", grad_valid, 1'b1);
            if (grad_valid) chk("hold_data", grad_data, held);
        end
        hold_chk = 1'b0;
        if (grad_valid) begin
            if (q.size() == 0) begin
                chk("spurious_grad", grad_valid, 1'b0);
            end else if (grad_ready) begin
                e = q.pop_front();
                chk("grad_data", grad_data, e.val);
                chk("grad_last", grad_last, (n_ret == exp_n - 1));
                if (chk_lat) chk("latency", cyc - e.c, LAT);
                n_ret++;
                last_beat = cyc;
            end else begin
                held     = grad_data;
                hold_chk = 1'b1;
            end
        end else if (grad_last) begin
            chk("last_wo_valid", grad_last, 1'b0);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) n_busy++;
    endtask

    task automatic step();
        logic took;
        @(negedge clk);
        monitor();
        took = dot_ready;
        @(posedge clk);
        #1;
        if (took) begin
            si++;
            dot_data   = dot_of(si);
            label_data = lab_of(si);
        end
        if (tog) label_valid = ~label_valid;
    endtask

    task automatic start_batch(int n, int mu);
        start       = 1'b1;
        num_samples = CW'(n);
        mu_cfg      = IW'(mu);
        mu_m        = IW'(mu);
        exp_n       = n;
        n_iss       = 0;
        n_ret       = 0;
        n_done      = 0;
        n_busy      = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(string tag, int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        step();
        chk({tag, "_one_done"}, n_done, 1);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
        chk({tag, "_q_empty"}, q.size(), 0);
    endtask

    initial begin
        int k, s0;
        total = 0; bad = 0; cyc = 0; si = 0;
        n_iss = 0; n_ret = 0; n_done = 0; n_busy = 0;
        first_iss = 0; last_iss = 0; last_beat = 0; done_cyc = 0;
        exp_n = 0; mu_m = '0; chk_lat = 1'b0; hold_chk = 1'b0; tog = 1'b0; held = '0;
        rst_n = 1'b0; start = 1'b0; num_samples = '0; mu_cfg = '0;
        dot_valid = 1'b0; label_valid = 1'b0; grad_ready = 1'b1;
        dot_data = dot_of(0); label_data = lab_of(0);

        repeat (3) step();
        chk_zero("reset_state");
        rst_n = 1'b1;
        step();
        dot_valid   = 1'b1;
        label_valid = 1'b1;

        // basic batch of 4, full throughput
        chk_lat = 1'b1;
        start_batch(4, 3);
        wait_done("t1", 40);
        chk("t1_issues", n_iss, 4);
        chk("t1_back_to_back", last_iss - first_iss, 3);
        chk("t1_beats", n_ret, 4);
        chk("t1_done_timing", done_cyc - last_beat, 1);

        // empty batch
        start_batch(0, 5);
        wait_done("t2", 10);
        chk("t2_busy_cycles", n_busy, 2);
        chk("t2_no_issue", n_iss, 0);
        chk("t2_no_beats", n_ret, 0);

        // output stall for 5 cycles from first grad_valid
        chk_lat    = 1'b0;
        grad_ready = 1'b0;
        start_batch(3, 6);
        k = 0;
        while (!grad_valid && k < 20) begin
            step();
            k++;
        end
        chk("t3_gv_seen", grad_valid, 1'b1);
        repeat (5) step();
        grad_ready = 1'b1;
        wait_done("t3", 40);
        chk("t3_issues", n_iss, 3);
        chk("t3_beats", n_ret, 3);
        chk_lat = 1'b1;

        // label stream valid every other cycle
        tog = 1'b1;
        s0  = si;
        start_batch(5, 65534);
        wait_done("t4", 60);
        chk("t4_issues", n_iss, 5);
        chk("t4_beats", n_ret, 5);
        chk("t4_consumed", si - s0, 5);
        tog         = 1'b0;
        label_valid = 1'b1;

        // second start during RUN must be ignored
        start_batch(5, 2);
        step();
        start       = 1'b1;
        num_samples = CW'(9);
        mu_cfg      = IW'(7);
        step();
        start = 1'b0;
        wait_done("t5", 60);
        chk("t5_issues", n_iss, 5);
        chk("t5_beats", n_ret, 5);

        // reset in the middle of a batch, then a clean batch
        start_batch(6, 5);
        k = 0;
        while (n_iss < 2 && k < 20) begin
            step();
            k++;
        end
        chk("t6_two_issued", n_iss, 2);
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async_clear");
        repeat (2) step();
        chk("t6_no_done", n_done, 0);
        rst_n = 1'b1;
        step();
        start_batch(3, 4);
        wait_done("t6", 40);
        chk("t6_issues", n_iss, 3);
        chk("t6_beats", n_ret, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
